// File: rtl/instrmem_param.sv
// Byte-organised, writable instruction memory serving big-endian 32-bit words.
// A registered fetch port and a byte-load port sit in front of a self-clearing array.
module instrmem_param #(
  parameter int          DEPTH_BYTES = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          LD_AW       = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ok,
  output logic        ld_err,
  output logic        ready,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault_misalign,
  output logic        fault_range
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [31:0]      DEPTH32   = 32'(DEPTH_BYTES);
  localparam logic [31:0]      LAST_PC   = 32'(DEPTH_BYTES - 4);
  localparam logic [LD_AW-1:0] LAST_BYTE = LD_AW'(DEPTH_BYTES - 1);

  state_t           state;
  logic [LD_AW-1:0] clr_cnt;
  logic [7:0]       mem [DEPTH_BYTES];

  logic             ld_in_range;
  logic             f_mis;
  logic             f_rng;
  logic [LD_AW-1:0] f_idx;
  logic [31:0]      rd_word;

  // Full 32-bit compares so high address bits never alias into the array.
  always_comb begin
    ld_in_range = (ld_addr < DEPTH32);
    f_mis       = (pc[1:0] != 2'b00);
    f_rng       = (pc > LAST_PC);
    f_idx       = pc[LD_AW-1:0];
    rd_word     = {mem[f_idx], mem[f_idx + LD_AW'(1)],
                   mem[f_idx + LD_AW'(2)], mem[f_idx + LD_AW'(3)]};
  end

  // NOTE: the array has no reset port on purpose; the CLEAR sweep zeroes it,
  // which keeps it mappable onto plain RAM without a per-bit reset tree.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= 8'h00;
    else if (ld_we && !clr && ld_in_range)
      mem[ld_addr[LD_AW-1:0]] <= ld_data;
  end

  // NOTE: all state and outputs use non-blocking assignments, so the fetch
  // read above sees the array contents from before any same-edge load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      ready          <= 1'b0;
      instr          <= 32'h0;
      instr_valid    <= 1'b0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
      ld_ok          <= 1'b0;
      ld_err         <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      ld_ok       <= 1'b0;
      ld_err      <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + LD_AW'(1);
          if (clr_cnt == LAST_BYTE) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // A fetch in the clr cycle is still answered from pre-clear contents.
          if (fetch_req) begin
            instr_valid    <= 1'b1;
            fault_misalign <= f_mis;
            fault_range    <= f_rng;
            instr          <= (f_mis || f_rng) ? NOP_WORD : rd_word;
          end
          if (clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end else if (ld_we) begin
            ld_ok  <= ld_in_range;
            ld_err <= !ld_in_range;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
